// File: rtl/imem_fetch_port_if.sv
// imem_fetch_port_if: fetch request/response handshake between the fetch stage (master) and the instruction store (slave).
interface imem_fetch_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_instr;
    logic              resp_fault;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_fault
    );
endinterface

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: clocked instruction store with a one-deep valid/ready fetch port, a load port and flush.
// Define IMEM_FAULT_CHECK_EN to flag misaligned and out-of-range fetch addresses in resp_fault.
module imem_fetch_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_fetch_port_if.slave  bus,
    input  logic              flush,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [DATA_W-1:0] load_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d, fault_q, fault_d;
    logic              accept, fault_w;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;

    assign addr = bus.req_addr;
    assign idx  = addr[IDX_W+1:2];

    assign bus.req_ready  = !flush && (!valid_q || bus.resp_ready);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = valid_q;
    assign bus.resp_instr = instr_q;
    assign bus.resp_fault = fault_q;

`ifdef IMEM_FAULT_CHECK_EN
    assign fault_w = (addr[1:0] != 2'b00) || ((addr >> (IDX_W + 2)) != '0);
`else
    logic unused_addr;
    assign unused_addr = ^addr;
    assign fault_w     = 1'b0;
`endif

    // accept implies no flush, so flush and consumption both reduce to a clear
    always_comb begin
        valid_d = accept || (valid_q && !flush && !bus.resp_ready);
        instr_d = accept ? mem_q[idx] : instr_q;
        fault_d = accept ? fault_w : fault_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // unreset store; a same-edge fetch of this index sees the old word
    always_ff @(posedge clk) begin
        if (load_en) mem_q[load_idx] <= load_data;
    end
endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: directed literal checks plus randomized traffic against a queue-free behavioural model.
module tb_imem_fetch_port;
    localparam int DEPTH = 256;
`ifdef IMEM_FAULT_CHECK_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk = 0, rst_n = 0, flush = 0, load_en = 0;
    logic [7:0]  load_idx = 0;
    logic [31:0] load_data = 0;
    int          checks = 0, failures = 0;

    imem_fetch_port_if #(.DATA_W(32), .ADDR_W(32)) bus();

    imem_fetch_port #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: word-addressed store, plus the single response the consumer can currently see.
    logic [31:0] mm [DEPTH];
    bit          kn [DEPTH];
    logic        m_valid = 0, m_fault = 0;
    logic [31:0] m_instr = 0;
    bit          m_known = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0;
            m_instr <= 0;
            m_fault <= 0;
            m_known <= 1;
        end else begin : upd
            bit acc;
            int unsigned w;
            acc = bus.req_valid && !flush && (!m_valid || bus.resp_ready);
            w = (bus.req_addr / 4) % DEPTH;
            if (acc) begin
                m_valid <= 1;
                m_instr <= mm[w];
                m_known <= kn[w];
                m_fault <= FE && ((bus.req_addr % 4 != 0) || (bus.req_addr >= 4 * DEPTH));
            end else if (flush || bus.resp_ready) begin
                m_valid <= 0;
            end
            if (load_en) begin
                mm[load_idx] <= load_data;
                kn[load_idx] <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready", 32'(bus.req_ready), 32'(!flush && (!m_valid || bus.resp_ready)));
            check("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
            if (m_valid && m_known) begin
                check("resp_instr", bus.resp_instr, m_instr);
                check("resp_fault", 32'(bus.resp_fault), 32'(m_fault));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [31:0] d);
        load_en = 1; load_idx = 8'(i); load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.req_valid = 1; bus.req_addr = a;
        tick();
    endtask

    initial begin
        bit pend;
        bus.req_valid = 1; bus.req_addr = 0; bus.resp_ready = 1;
        repeat (3) tick();
        check("rst_valid", 32'(bus.resp_valid), 0);
        check("rst_instr", bus.resp_instr, 0);
        check("rst_fault", 32'(bus.resp_fault), 0);
        rst_n = 1;
        tick();
        check("first_accept", 32'(bus.resp_valid), 1);
        bus.req_valid = 0;
        load(0, 32'h00000013); load(1, 32'h00100093); load(2, 32'h00200113);
        load(3, 32'h00300193); load(5, 32'hDEADBEEF); load(255, 32'hCAFEF00D);
        fetch(32'h0); check("stream0", bus.resp_instr, 32'h00000013);
        fetch(32'h4); check("stream1", bus.resp_instr, 32'h00100093);
        fetch(32'h8); check("stream2", bus.resp_instr, 32'h00200113);
        fetch(32'hC); check("stream3", bus.resp_instr, 32'h00300193);
        check("stream_valid", 32'(bus.resp_valid), 1);
        fetch(32'h4);
        bus.resp_ready = 0; bus.req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(bus.req_ready), 0);
            check("bp_instr", bus.resp_instr, 32'h00100093);
            tick();
        end
        bus.resp_ready = 1;
        #1 check("bp_release", 32'(bus.req_ready), 1);
        tick(); check("bp_next", bus.resp_instr, 32'h00200113);
        bus.req_addr = 32'hC; flush = 1;
        #1 check("flush_ready", 32'(bus.req_ready), 0);
        tick(); check("flush_valid", 32'(bus.resp_valid), 0);
        flush = 0;
        #1 check("flush_after", 32'(bus.req_ready), 1);
        tick(); check("post_flush", bus.resp_instr, 32'h00300193);
        load_en = 1; load_idx = 5; load_data = 32'h12345678;
        fetch(32'h14); load_en = 0;
        check("rbw_old", bus.resp_instr, 32'hDEADBEEF);
        tick(); check("rbw_new", bus.resp_instr, 32'h12345678);
        fetch(32'h6);   check("f6_instr", bus.resp_instr, 32'h00100093);
        check("f6_fault", 32'(bus.resp_fault), 32'(FE));
        fetch(32'h400); check("f400_instr", bus.resp_instr, 32'h00000013);
        check("f400_fault", 32'(bus.resp_fault), 32'(FE));
        fetch(32'h3FC); check("f3fc_instr", bus.resp_instr, 32'hCAFEF00D);
        check("f3fc_fault", 32'(bus.resp_fault), 0);
        #2 rst_n = 0;
        #1 check("midrst_valid", 32'(bus.resp_valid), 0);
        check("midrst_instr", bus.resp_instr, 0);
        tick(); rst_n = 1;
        fetch(32'h0); check("preserved", bus.resp_instr, 32'h00000013);
        bus.req_valid = 0;
        pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend) begin
                bus.req_valid = $urandom_range(0, 3) != 0;
                bus.req_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            end
            bus.resp_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 9) == 0;
            load_en = $urandom_range(0, 3) == 0;
            load_idx = 8'($urandom);
            load_data = $urandom;
            #1 pend = bus.req_valid && !bus.req_ready;
            tick();
        end
        load_en = 0; flush = 0; bus.req_valid = 0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
